msg_event_logger: RTL and testbench

Hardware successor to the software message logger. It captures graded events from CH_NUM channels, each with a type, severity, action and payload, and timestamps them. Events whose severity meets a runtime threshold are buffered in a FIFO for valid/ready readout. Every accepted event is tallied per type regardless of threshold, and sticky stop and exit requests are raised for the testbench or system controller.

---
 rtl/msg_event_logger.sv | 262 ++++++++++++++++++++++++++
 tb/tb_msg_event_logger.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_event_logger.sv
// msg_event_logger: timestamped, severity-filtered event capture.
//
// Each of CH_NUM channels presents an event (type, severity, action, payload).
// An event is accepted when its channel's 1-entry holding register is empty.
// Otherwise it is dropped and counted in drop_cnt. Accepted events are tallied
// per type, and their STOP/EXIT actions raise sticky requests. Only events whose
// severity meets svrt_thold load the holding register. A round-robin arbiter
// moves one holding register per cycle into a show-ahead FIFO, which is read
// out with a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ev_valid/type/svrt/act   per-channel event strobe and attributes (2 bits each)
//   ev_msg                   per-channel payload, MSG_W bits per channel
//   svrt_thold               minimum severity that is enqueued
//   clear                    synchronous flush of buffers and counters
//   ack                      clears stop_req
//   out_valid/out_ready      FIFO head handshake
//   out_ts/ch/type/svrt/msg  FIFO head fields
//   type_cnt                 per-type accepted-event counters, INFO in the LSBs
//   drop_cnt                 events lost to a busy holding register
//   stop_req, exit_req       sticky action requests
module msg_event_logger #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned MSG_W  = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [CH_NUM-1:0]                           ev_valid,
    input  logic [2*CH_NUM-1:0]                         ev_type,
    input  logic [2*CH_NUM-1:0]                         ev_svrt,
    input  logic [2*CH_NUM-1:0]                         ev_act,
    input  logic [MSG_W*CH_NUM-1:0]                     ev_msg,
    input  logic [1:0]                                  svrt_thold,
    input  logic                                        clear,
    input  logic                                        ack,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [TS_W-1:0]                             out_ts,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] out_ch,
    output logic [1:0]                                  out_type,
    output logic [1:0]                                  out_svrt,
    output logic [MSG_W-1:0]                            out_msg,
    output logic [4*CNT_W-1:0]                          type_cnt,
    output logic [CNT_W-1:0]                            drop_cnt,
    output logic                                        stop_req,
    output logic                                        exit_req
);

    localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ENT_W = TS_W + CH_W + 4 + MSG_W;
    // Entry layout, LSB first: msg, svrt, type, ch, ts
    localparam int unsigned SV_LO = MSG_W;
    localparam int unsigned TY_LO = MSG_W + 2;
    localparam int unsigned CH_LO = MSG_W + 4;
    localparam int unsigned TS_LO = MSG_W + 4 + CH_W;

    localparam logic [1:0] ActStop = 2'd1;
    localparam logic [1:0] ActExit = 2'd2;

    // Per-channel views of the packed event inputs
    logic [1:0]       ch_type [CH_NUM];
    logic [1:0]       ch_svrt [CH_NUM];
    logic [1:0]       ch_act  [CH_NUM];
    logic [MSG_W-1:0] ch_msg  [CH_NUM];

    for (genvar g = 0; g < CH_NUM; g++) begin : g_split
        assign ch_type[g] = ev_type[2*g +: 2];
        assign ch_svrt[g] = ev_svrt[2*g +: 2];
        assign ch_act[g]  = ev_act[2*g +: 2];
        assign ch_msg[g]  = ev_msg[MSG_W*g +: MSG_W];
    end

    // State
    logic [TS_W-1:0]   ts_q;
    logic [CH_NUM-1:0] hold_vld_q;
    logic [TS_W-1:0]   hold_ts_q   [CH_NUM];
    logic [1:0]        hold_type_q [CH_NUM];
    logic [1:0]        hold_svrt_q [CH_NUM];
    logic [MSG_W-1:0]  hold_msg_q  [CH_NUM];
    logic [CH_W-1:0]   rr_q;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;
    logic [ENT_W-1:0]  last_q;
    logic [CNT_W-1:0]  tcnt_q [4];
    logic [CNT_W-1:0]  drop_q;
    logic              stop_q, exit_q;

    // Combinational
    logic [CH_NUM-1:0] accept, load, dropped, hold_free;
    logic              stop_set, exit_set;
    logic [4:0]        type_inc [4];
    logic [4:0]        drop_inc;
    logic              fifo_full, pop, can_push, push;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx, cand;
    logic [CH_W-1:0]   rr_d;
    logic [ENT_W-1:0]  push_ent, head;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [4:0] b);
        logic [CNT_W+4:0] s;
        s = {5'b0, a} + {{CNT_W{1'b0}}, b};
        if (s > {5'b0, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // Acceptance, filtering, actions and counter increments
    always_comb begin
        accept   = '0;
        load     = '0;
        dropped  = '0;
        stop_set = 1'b0;
        exit_set = 1'b0;
        drop_inc = '0;
        for (int t = 0; t < 4; t++) begin
            type_inc[t] = '0;
        end
        for (int i = 0; i < CH_NUM; i++) begin
            // A register granted this cycle still counts as full.
            accept[i]  = ev_valid[i] & ~hold_vld_q[i] & ~clear;
            dropped[i] = ev_valid[i] & hold_vld_q[i] & ~clear;
            load[i]    = accept[i] & (ch_svrt[i] >= svrt_thold);
            if (accept[i] && ch_act[i] == ActStop) stop_set = 1'b1;
            if (accept[i] && ch_act[i] == ActExit) exit_set = 1'b1;
            if (dropped[i]) drop_inc = drop_inc + 5'd1;
            for (int t = 0; t < 4; t++) begin
                if (accept[i] && ch_type[i] == 2'(t)) type_inc[t] = type_inc[t] + 5'd1;
            end
        end
    end

    // Round-robin arbiter and FIFO push/pop decode
    always_comb begin
        fifo_full = (cnt_q == (AW+1)'(DEPTH));
        out_valid = (cnt_q != '0);
        pop       = out_valid & out_ready;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
        can_push  = (~fifo_full | pop) & ~clear;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            cand = CH_W'((int'(rr_q) + k) % int'(CH_NUM));
            if (!gnt_vld && hold_vld_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        push = gnt_vld & can_push;
        rr_d = rr_q;
        if (push) begin
            rr_d = (gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
        push_ent = {hold_ts_q[gnt_idx], gnt_idx, hold_type_q[gnt_idx],
                    hold_svrt_q[gnt_idx], hold_msg_q[gnt_idx]};
        hold_free = '0;
        if (push) hold_free[gnt_idx] = 1'b1;
    end

    // Show-ahead head; the last shown entry is held while the FIFO is empty.
    always_comb begin
        head     = out_valid ? mem_q[rd_q] : last_q;
        out_msg  = head[MSG_W-1:0];
        out_svrt = head[SV_LO +: 2];
        out_type = head[TY_LO +: 2];
        out_ch   = head[CH_LO +: CH_W];
        out_ts   = head[TS_LO +: TS_W];
    end

    for (genvar t = 0; t < 4; t++) begin : g_tcnt
        assign type_cnt[CNT_W*t +: CNT_W] = tcnt_q[t];
    end
    assign drop_cnt = drop_q;
    assign stop_req = stop_q;
    assign exit_req = exit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            hold_vld_q <= '0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            drop_q     <= '0;
            stop_q     <= 1'b0;
            exit_q     <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                hold_ts_q[i]   <= '0;
                hold_type_q[i] <= '0;
                hold_svrt_q[i] <= '0;
                hold_msg_q[i]  <= '0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            for (int t = 0; t < 4; t++) begin
                tcnt_q[t] <= '0;
            end
        end else begin
            ts_q <= ts_q + TS_W'(1);

            if (exit_set) exit_q <= 1'b1;
            if (stop_set) begin
                stop_q <= 1'b1;
            end else if (ack) begin
                stop_q <= 1'b0;
            end

            if (out_valid) last_q <= mem_q[rd_q];

            for (int i = 0; i < CH_NUM; i++) begin
                if (load[i]) begin
                    hold_ts_q[i]   <= ts_q;
                    hold_type_q[i] <= ch_type[i];
                    hold_svrt_q[i] <= ch_svrt[i];
                    hold_msg_q[i]  <= ch_msg[i];
                end
            end

            if (clear) begin
                hold_vld_q <= '0;
                rr_q       <= '0;
                wr_q       <= '0;
                rd_q       <= '0;
                cnt_q      <= '0;
                drop_q     <= '0;
                for (int t = 0; t < 4; t++) begin
                    tcnt_q[t] <= '0;
                end
            end else begin
                // load and hold_free never hit the same channel: load needs it empty.
                hold_vld_q <= (hold_vld_q & ~hold_free) | load;
                rr_q       <= rr_d;
                drop_q     <= sat_add(drop_q, drop_inc);
                for (int t = 0; t < 4; t++) begin
                    tcnt_q[t] <= sat_add(tcnt_q[t], type_inc[t]);
                end
                if (push) begin
                    mem_q[wr_q] <= push_ent;
                    wr_q        <= wr_q + AW'(1);
                end
                if (pop) rd_q <= rd_q + AW'(1);
                if (push && !pop) begin
                    cnt_q <= cnt_q + (AW+1)'(1);
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_event_logger.sv
// Self-checking bench for msg_event_logger (CH_NUM=4, MSG_W=16, DEPTH=16).
// Expected FIFO entries are queued as events are driven and compared as the
// DUT hands them out.
module tb_msg_event_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ev_valid;
    logic [7:0]  ev_type, ev_svrt, ev_act;
    logic [63:0] ev_msg;
    logic [1:0]  svrt_thold;
    logic        clear, ack, out_ready;
    logic        out_valid;
    logic [31:0] out_ts;
    logic [1:0]  out_ch, out_type, out_svrt;
    logic [15:0] out_msg;
    logic [63:0] type_cnt;
    logic [15:0] drop_cnt;
    logic        stop_req, exit_req;

    msg_event_logger #(
        .CH_NUM(4), .MSG_W(16), .DEPTH(16), .TS_W(32), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_type(ev_type),
        .ev_svrt(ev_svrt), .ev_act(ev_act), .ev_msg(ev_msg),
        .svrt_thold(svrt_thold), .clear(clear), .ack(ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_ch(out_ch), .out_type(out_type), .out_svrt(out_svrt),
        .out_msg(out_msg), .type_cnt(type_cnt), .drop_cnt(drop_cnt),
        .stop_req(stop_req), .exit_req(exit_req)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt [4];
    int          exp_drop;
    logic [53:0] sb [$];
    logic [31:0] tb_ts = '0;

    // Reference timestamp: cycles since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [53:0] ent(input logic [31:0] ts, input logic [1:0] ch,
                                        input logic [1:0] ty, input logic [1:0] sv,
                                        input logic [15:0] msg);
        return {ts, ch, ty, sv, msg};
    endfunction

    // Scoreboard: compare each handed-out head against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                check("entry", 64'({out_ts, out_ch, out_type, out_svrt, out_msg}),
                      64'(sb.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input int ch, input logic [1:0] ty, input logic [1:0] sv,
                          input logic [1:0] act, input logic [15:0] msg);
        ev_valid = ev_valid | (4'b1 << ch);
        ev_type  = (ev_type & ~(8'h3 << (2*ch))) | (8'(ty) << (2*ch));
        ev_svrt  = (ev_svrt & ~(8'h3 << (2*ch))) | (8'(sv) << (2*ch));
        ev_act   = (ev_act & ~(8'h3 << (2*ch))) | (8'(act) << (2*ch));
        ev_msg   = (ev_msg & ~(64'hFFFF << (16*ch))) | (64'(msg) << (16*ch));
    endtask

    task automatic idle();
        ev_valid = '0;
    endtask

    task automatic zero_exp();
        for (int t = 0; t < 4; t++) exp_cnt[t] = 0;
        exp_drop = 0;
    endtask

    task automatic check_cnts(input string tag);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("%s_type_cnt%0d", tag, t),
                  64'((type_cnt >> (16*t)) & 64'hFFFF), 64'(exp_cnt[t]));
        end
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    task automatic wait_drain(input int lim);
        for (int k = 0; k < lim && sb.size() != 0; k++) step();
        check("drain_done", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_fields"}, 64'({out_ts, out_ch, out_type, out_svrt, out_msg}), 64'(0));
        check({tag, "_type_cnt"}, type_cnt, 64'(0));
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(0));
        check({tag, "_reqs"}, 64'({stop_req, exit_req}), 64'(0));
    endtask

    initial begin
        bit hold_full, accepted, grant;
        int fcnt;
        ev_valid = '0; ev_type = '0; ev_svrt = '0; ev_act = '0; ev_msg = '0;
        svrt_thold = 2'd0; clear = 1'b0; ack = 1'b0; out_ready = 1'b1;
        zero_exp();

        // Reset state
        #12;
        check_all_zero("reset");
        #11 rst = 1'b0;

        // Single WARN/HIGH event on ch2 at ts=10, two-cycle latency
        for (int k = 0; k < 50 && tb_ts != 32'd10; k++) step();
        set_ev(2, 2'd1, 2'd2, 2'd0, 16'h1234);
        sb.push_back(ent(tb_ts, 2'd2, 2'd1, 2'd2, 16'h1234));
        exp_cnt[1]++;
        step(); idle();
        check("lat_t1_valid", 64'(out_valid), 64'(0));
        check_cnts("single");
        step();
        check("lat_t2_valid", 64'(out_valid), 64'(1));
        check("lat_t2_ts", 64'(out_ts), 64'(10));
        step();
        wait_drain(10);

        // clear resets pointer and counters
        clear = 1'b1; step(); clear = 1'b0;
        zero_exp();
        check_cnts("clear1");

        // All four channels at once, pointer at 0: ch0..3 on consecutive cycles
        for (int c = 0; c < 4; c++) begin
            set_ev(c, 2'd0, 2'd0, 2'd0, 16'hA0 + 16'(c));
            sb.push_back(ent(tb_ts, 2'(c), 2'd0, 2'd0, 16'hA0 + 16'(c)));
        end
        exp_cnt[0] += 4;
        step(); idle();
        check_cnts("burst");
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("burst_valid%0d", k), 64'(out_valid), 64'(1));
            step();
        end
        check("burst_end_valid", 64'(out_valid), 64'(0));
        check("burst_sb_empty", 64'(sb.size()), 64'(0));

        // Threshold filtering and sticky actions
        svrt_thold = 2'd2;
        set_ev(0, 2'd2, 2'd1, 2'd1, 16'hE001);
        set_ev(1, 2'd3, 2'd3, 2'd2, 16'hF001);
        sb.push_back(ent(tb_ts, 2'd1, 2'd3, 2'd3, 16'hF001));
        exp_cnt[2]++; exp_cnt[3]++;
        step(); idle();
        check("act_reqs", 64'({stop_req, exit_req}), 64'(2'b11));
        check_cnts("filter");
        wait_drain(10);
        ack = 1'b1; step(); ack = 1'b0;
        check("ack_reqs", 64'({stop_req, exit_req}), 64'(2'b01));
        ack = 1'b1;
        set_ev(2, 2'd0, 2'd2, 2'd1, 16'h5700);
        sb.push_back(ent(tb_ts, 2'd2, 2'd0, 2'd2, 16'h5700));
        exp_cnt[0]++;
        step(); ack = 1'b0; idle();
        check("stop_beats_ack", 64'(stop_req), 64'(1));
        wait_drain(10);
        svrt_thold = 2'd0;

        // Fill: ch0 every cycle, consumer stalled
        out_ready = 1'b0;
        hold_full = 1'b0; fcnt = 0;
        for (int c = 0; c < 40; c++) begin
            set_ev(0, 2'd2, 2'd1, 2'd0, 16'(c));
            accepted = !hold_full;
            grant    = hold_full && fcnt < 16;
            if (accepted) begin
                sb.push_back(ent(tb_ts, 2'd0, 2'd2, 2'd1, 16'(c)));
                exp_cnt[2]++;
            end else begin
                exp_drop++;
            end
            step();
            if (grant) begin fcnt++; hold_full = 1'b0; end
            if (accepted) hold_full = 1'b1;
        end
        idle();
        check("fill_valid", 64'(out_valid), 64'(1));
        check_cnts("fill");
        // Drain 17: first pop coincides with the pending holding-register push
        out_ready = 1'b1;
        step();
        check("full_pushpop_valid", 64'(out_valid), 64'(1));
        wait_drain(40);
        check("drain_valid", 64'(out_valid), 64'(0));

        // clear mid-stream
        out_ready = 1'b0;
        set_ev(1, 2'd1, 2'd0, 2'd0, 16'h0C01); step(); idle(); step();
        set_ev(1, 2'd1, 2'd0, 2'd0, 16'h0C02); step(); idle(); step();
        clear = 1'b1;
        set_ev(2, 2'd3, 2'd3, 2'd2, 16'h0C03);
        step(); clear = 1'b0; idle();
        sb.delete();
        zero_exp();
        check("clear_valid", 64'(out_valid), 64'(0));
        check_cnts("clear2");
        check("clear_keeps_reqs", 64'({stop_req, exit_req}), 64'(2'b11));
        out_ready = 1'b1;
        step();
        set_ev(1, 2'd1, 2'd0, 2'd0, 16'h0C04);
        sb.push_back(ent(tb_ts, 2'd1, 2'd1, 2'd0, 16'h0C04));
        exp_cnt[1]++;
        step(); idle();
        wait_drain(10);
        check_cnts("post_clear");

        // Asynchronous reset with 5 entries queued and stop_req set
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_ev(3, 2'd0, 2'd1, 2'd0, 16'h7700 + 16'(k)); step(); idle(); step();
        end
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        check("pre_rst_stop", 64'(stop_req), 64'(1));
        #3 rst = 1'b1;
        #2;
        check_all_zero("async_rst");
        #2 rst = 1'b0;
        zero_exp();
        out_ready = 1'b1;
        step(); step(); step();
        set_ev(0, 2'd0, 2'd0, 2'd0, 16'h5A5A);
        sb.push_back(ent(tb_ts, 2'd0, 2'd0, 2'd0, 16'h5A5A));
        exp_cnt[0]++;
        step(); idle();
        step();
        check("post_rst_ts", 64'(out_ts), 64'(3));
        wait_drain(10);
        check_cnts("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
